// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: 32x32 signed -> 64-bit signed product.
// One ADD/SHIFT pair per multiplier bit, sharing a single 32-bit carry-select adder.

// 32-bit carry-select adder built from 4-bit blocks; each block precomputes
// both carry-in outcomes and the incoming carry selects between them.
module carrySelectAdder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    localparam int unsigned W   = 32;
    localparam int unsigned BLK = 4;
    localparam int unsigned NB  = W / BLK;

    logic [NB:0] carry;

    assign carry[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLK:0] res0;
        logic [BLK:0] res1;

        // Block result assuming carry-in 0 and carry-in 1
        assign res0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign res1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]}
                    + {{BLK{1'b0}}, 1'b1};

        // Real incoming carry picks the precomputed result
        assign sum[g*BLK +: BLK] = carry[g] ? res1[BLK-1:0] : res0[BLK-1:0];
        assign carry[g+1]        = carry[g] ? res1[BLK]     : res0[BLK];
    end

    assign cout = carry[NB];
endmodule

module booth_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    localparam int unsigned W  = 32;
    localparam int unsigned AW = W + 1;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = 5;

    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic [W-1:0]    q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [W-1:0]    m_q, m_d;
    logic [CW-1:0]   count_q, count_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   product_q, product_d;

    logic [W-1:0]    add_b_c;
    logic            add_cin_c;
    logic [W-1:0]    add_sum_c;
    logic            add_cout_c;
    logic            last_shift_c;

    assign last_shift_c = (state_q == S_SHIFT) && (count_q == LAST_CNT);

    // Booth decode of {Q[0], Qm1}: add M, subtract M (~M + 1) or add nothing
    always_comb begin
        add_b_c   = '0;
        add_cin_c = 1'b0;
        case ({q_q[0], qm1_q})
            2'b01: add_b_c = m_q;
            2'b10: begin
                add_b_c   = ~m_q;
                add_cin_c = 1'b1;
            end
            default: begin
                add_b_c   = '0;
                add_cin_c = 1'b0;
            end
        endcase
    end

    // The only adder in the datapath
    carrySelectAdder u_csa (
        .a    (a_q[W-1:0]),
        .b    (add_b_c),
        .cin  (add_cin_c),
        .sum  (add_sum_c),
        .cout (add_cout_c)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start only matters in IDLE, DONE always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADD;
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = (count_q == LAST_CNT) ? S_DONE : S_ADD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy/done track the upcoming state so they are registered
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        product_d = product_q;
        // Product is the post-shift {A[31:0], Q}, i.e. {A, Q[31:1]} pre-shift
        if (last_shift_c) begin
            product_d = {a_q, q_q[W-1:1]};
        end
    end

    // Datapath next values for the accumulator, multiplier and counter
    always_comb begin
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    m_d     = multiplicand;
                    count_d = '0;
                end
            end
            S_ADD: begin
                // Bit 32 is the sign extension of a 33-bit add with sign-extended b
                a_d = {a_q[AW-1] ^ add_b_c[W-1] ^ add_cout_c, add_sum_c};
            end
            S_SHIFT: begin
                a_d   = {a_q[AW-1], a_q[AW-1:1]};
                q_d   = {a_q[0], q_q[W-1:1]};
                qm1_d = q_q[0];
                if (count_q != LAST_CNT) begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                a_d = a_q;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule
